uart_core: RTL and testbench
============================

Name: uart_core

Overview:
- Full-duplex UART: one 8N1 transmitter and one 8N1 receiver sharing a single system clock.
- Sits between a byte-wide valid/busy host interface and the serial pins o_tx and i_rx.
- Transmitter and receiver are independent. o_tx can be looped to i_rx for self-test.

Parameters:
- DATA_WIDTH, 8: data bits per frame.
- FREQ, 10000000: i_clk frequency in Hz.
- BAUD, 9600: serial bit rate.
- CLKS_PER_BIT (localparam): FREQ/BAUD, truncated integer division. Default value is 1041.

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_tx_data  in  DATA_WIDTH  byte to transmit; sampled only when a send is accepted.
- i_tx_valid  in  1  send request.
- o_tx_busy  out  1  transmitter is occupied.
- o_rx_data  out  DATA_WIDTH  last correctly received byte.
- o_rx_valid  out  1  one-cycle pulse when a new byte is available.
- o_tx  out  1  serial output; idles high.
- i_rx  in  1  serial input; asynchronous to i_clk.

Behaviour:
- Reset values: o_tx=1, o_tx_busy=0, o_rx_data=0, o_rx_valid=0. Both state machines go to IDLE and all counters clear.
- Reset asserted mid-frame aborts the frame immediately. o_tx returns high on the next edge.
- Frame format: start bit (0), DATA_WIDTH data bits LSB first, one stop bit (1). No parity.
- Every bit, including the stop bit, lasts exactly CLKS_PER_BIT cycles.

TX state machine (IDLE, START, DATA, STOP):
- Send acceptance: on an edge where i_tx_valid=1 and o_tx_busy=0, latch i_tx_data. On that same edge set o_tx_busy=1, o_tx=0 and enter START.
- i_tx_valid while busy is ignored; nothing is queued.
- i_tx_data changes after acceptance have no effect.
- Bit progression: START lasts CLKS_PER_BIT cycles, then DATA. DATA sends bits 0..DATA_WIDTH-1, then STOP.
- After STOP's CLKS_PER_BIT cycles, return to IDLE with o_tx_busy=0 and o_tx=1.
- o_tx_busy is therefore high for exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
- Back-to-back sends: a request on the first cycle busy is low is accepted. There are zero idle cycles between frames.
- o_tx is driven from a register and must be glitch-free.

RX state machine (IDLE, START, DATA, STOP):
- i_rx passes through a 2-flop synchronizer. All receive decisions use the synchronized value.
- IDLE: a synchronized low starts START and clears the bit counter.
- START: wait CLKS_PER_BIT/2 cycles, then re-check the line.
  - Still low: enter DATA.
  - High: treat as a glitch and return to IDLE.
- DATA: sample each bit once, at CLKS_PER_BIT intervals from the start mid-point. Shift in LSB first.
- STOP: sample at the stop-bit mid-point.
  - If 1: load o_rx_data and pulse o_rx_valid high for exactly one cycle, then go to IDLE.
  - If 0 (framing error): discard the byte. No pulse, o_rx_data unchanged. Wait for the line to return high, then go to IDLE.
- o_rx_data holds its value until the next valid frame.
- After a stop sample the receiver is ready within 1 cycle, so back-to-back frames are received correctly.
- Loopback latency: the o_rx_valid pulse occurs (DATA_WIDTH+1.5)*CLKS_PER_BIT + 3 ±1 cycles after the TX start edge. This is before o_tx_busy falls.

Decomposition:
- Shared package uart_pkg:
  - state enums for TX and RX: IDLE, START, DATA, STOP;
  - frame constants: START_BIT=0, STOP_BIT=1;
  - a function computing CLKS_PER_BIT from FREQ and BAUD.
- Natural split is two sub-modules, uart_tx and uart_rx. Each has its own baud counter and bit counter.
- uart_core only instantiates uart_tx and uart_rx and wires the ports.

Test Plan:
- Reset check: hold i_rst for 10 cycles -> o_tx=1, o_tx_busy=0, o_rx_valid=0, o_rx_data=0.
- Loopback 0xF0: o_tx tied to i_rx; pulse i_tx_valid for 1 cycle with i_tx_data=0xF0 ->
  - o_tx waveform 0,0,0,0,0,1,1,1,1,1 with each bit 1041 cycles;
  - o_tx_busy high for 10410 cycles;
  - a single o_rx_valid pulse with o_rx_data=0xF0.
- Second byte after busy: wait for o_tx_busy to fall plus 1 cycle, send 0x5A -> serial bits 0,0,1,0,1,1,0,1,0,1; o_rx_data=0x5A.
- Busy ignore: during the 0xF0 frame, pulse i_tx_valid with 0x33 -> no second frame; o_tx returns idle after the stop bit.
- RX framing error and glitch: drive i_rx with 0xA5 and the stop bit forced 0 -> no o_rx_valid and o_rx_data unchanged. Then drive a 300-cycle low glitch -> no reception.
- Reset mid-frame: assert i_rst during data bit 3 of a 0x81 send -> next cycle o_tx=1 and busy=0. A fresh 0x81 send then completes normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types, frame constants and baud divisor helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  typedef uart_state_t tx_state_t;
  typedef uart_state_t rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int unsigned clks_per_bit(input int unsigned freq, input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: synchronizes the line, samples mid-bit, flags framing errors.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 1041
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_t             state, state_nxt;
  logic                  rx_meta, rx_sync;
  logic [CNT_W-1:0]      baud_cnt, baud_cnt_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt, data_nxt;
  logic                  valid_nxt, frame_err, frame_err_nxt;
  logic                  bit_end, half_end, last_bit;

  assign bit_end  = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign half_end = (baud_cnt == CNT_W'(CLKS_PER_BIT / 2 - 1));
  assign last_bit = (bit_cnt == BIT_W'(DATA_WIDTH - 1));

  // Two-flop synchronizer for the asynchronous serial input.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= STOP_BIT;
      rx_sync <= STOP_BIT;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      data      <= '0;
      valid     <= 1'b0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      frame_err <= frame_err_nxt;
      data      <= data_nxt;
      valid     <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (rx_sync == START_BIT) state_nxt = START;
      START: if (half_end) state_nxt = (rx_sync == START_BIT) ? DATA : IDLE;
      DATA:  if (bit_end && last_bit) state_nxt = STOP;
      STOP: begin
        // After a bad stop bit, hold here until the line is back to idle.
        if (frame_err) begin
          if (rx_sync == STOP_BIT) state_nxt = IDLE;
        end else if (bit_end && rx_sync == STOP_BIT) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    baud_cnt_nxt  = bit_end ? '0 : baud_cnt + CNT_W'(1);
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    frame_err_nxt = frame_err;
    data_nxt      = data;
    valid_nxt     = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_nxt  = '0;
        bit_cnt_nxt   = '0;
        frame_err_nxt = 1'b0;
      end
      START: baud_cnt_nxt = half_end ? '0 : baud_cnt + CNT_W'(1);
      DATA: begin
        if (bit_end) begin
          shreg_nxt   = DATA_WIDTH'({rx_sync, shreg} >> 1);
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
        end
      end
      STOP: begin
        if (frame_err) begin
          baud_cnt_nxt = baud_cnt;
        end else if (bit_end) begin
          if (rx_sync == STOP_BIT) begin
            data_nxt  = shreg;
            valid_nxt = 1'b1;
          end else begin
            frame_err_nxt = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: accepts a byte when idle and shifts it out LSB first.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 1041
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  busy,
  output logic                  tx
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  tx_state_t             state, state_nxt;
  logic [CNT_W-1:0]      baud_cnt, baud_cnt_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt, shifted;
  logic                  busy_nxt, tx_nxt;
  logic                  bit_end, last_bit;

  assign bit_end  = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign last_bit = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
  assign shifted  = shreg >> 1;

  // State and datapath registers; reset drops the line back to idle at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      busy     <= 1'b0;
      tx       <= STOP_BIT;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      busy     <= busy_nxt;
      tx       <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid)               state_nxt = START;
      START:   if (bit_end)             state_nxt = DATA;
      DATA:    if (bit_end && last_bit) state_nxt = STOP;
      STOP:    if (bit_end)             state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Next register values; the serial bit is decided one edge ahead so tx stays a flop output.
  always_comb begin
    baud_cnt_nxt = bit_end ? '0 : baud_cnt + CNT_W'(1);
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    busy_nxt     = busy;
    tx_nxt       = tx;
    case (state)
      IDLE: begin
        baud_cnt_nxt = '0;
        bit_cnt_nxt  = '0;
        if (valid) begin
          shreg_nxt = data;
          busy_nxt  = 1'b1;
          tx_nxt    = START_BIT;
        end
      end
      START: if (bit_end) tx_nxt = shreg[0];
      DATA: begin
        if (bit_end) begin
          shreg_nxt   = shifted;
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
          tx_nxt      = last_bit ? STOP_BIT : shifted[0];
        end
      end
      STOP: begin
        if (bit_end) begin
          busy_nxt = 1'b0;
          tx_nxt   = STOP_BIT;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: independent transmitter and receiver on one clock.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FREQ       = 10000000,
  parameter int unsigned BAUD       = 9600
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_tx_busy,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_tx,
  input  logic                  i_rx
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(FREQ, BAUD);

  uart_tx #(
    .DATA_WIDTH  (DATA_WIDTH),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (i_clk),
    .rst  (i_rst),
    .data (i_tx_data),
    .valid(i_tx_valid),
    .busy (o_tx_busy),
    .tx   (o_tx)
  );

  uart_rx #(
    .DATA_WIDTH  (DATA_WIDTH),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk  (i_clk),
    .rst  (i_rst),
    .rx   (i_rx),
    .data (o_rx_data),
    .valid(o_rx_valid)
  );

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: loopback frames, busy handling, RX errors, mid-frame reset.
module tb_uart_core;

  localparam int CPB  = 1041;
  localparam int HALF = CPB / 2;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_tx_data;
  logic       i_tx_valid;
  logic       o_tx_busy;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_tx;
  logic       i_rx;
  logic       loop;
  logic       rx_drv;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t0     = 0;
  int rx_cnt = 0;
  int rx_cyc = 0;

  assign i_rx = loop ? o_tx : rx_drv;

  uart_core dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_tx_data (i_tx_data),
    .i_tx_valid(i_tx_valid),
    .o_tx_busy (o_tx_busy),
    .o_rx_data (o_rx_data),
    .o_rx_valid(o_rx_valid),
    .o_tx      (o_tx),
    .i_rx      (i_rx)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Receive monitor: count pulses and remember when the last one arrived.
  always @(negedge i_clk) begin
    if (o_rx_valid) begin
      rx_cnt = rx_cnt + 1;
      rx_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called on a negedge; the request is accepted on the following posedge.
  task automatic send_byte(input logic [7:0] b);
    i_tx_data  = b;
    i_tx_valid = 1'b1;
    @(negedge i_clk);
    i_tx_valid = 1'b0;
    t0 = cyc;
  endtask

  // Samples o_tx mid-bit for a whole frame; bits[k] is frame bit k (start first).
  task automatic check_frame(input string tag, input logic [9:0] bits);
    check({tag, "_busy_start"}, o_tx_busy, 1);
    for (int k = 0; k < 10; k++) begin
      repeat (HALF) @(negedge i_clk);
      check($sformatf("%s_bit%0d", tag, k), o_tx, bits[k]);
      repeat (CPB - HALF - 1) @(negedge i_clk);
      if (k == 9) check({tag, "_busy_last"}, o_tx_busy, 1);
      @(negedge i_clk);
    end
    check({tag, "_busy_end"}, o_tx_busy, 0);
    check({tag, "_tx_idle"}, o_tx, 1);
  endtask

  task automatic check_rx(input string tag, input logic [7:0] d, input int n);
    int lat;
    lat = rx_cyc - t0;
    check({tag, "_rx_data"}, o_rx_data, d);
    check({tag, "_rx_cnt"}, rx_cnt, n);
    check({tag, "_rx_lat"}, (lat >= 9892 && lat <= 9893) ? 1 : 0, 1);
  endtask

  task automatic drive_rx(input logic [9:0] bits);
    for (int k = 0; k < 10; k++) begin
      rx_drv = bits[k];
      repeat (CPB) @(negedge i_clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    int lows;
    i_rst      = 1'b1;
    i_tx_data  = 8'h00;
    i_tx_valid = 1'b0;
    rx_drv     = 1'b1;
    loop       = 1'b0;

    repeat (10) @(negedge i_clk);
    check("rst_tx", o_tx, 1);
    check("rst_busy", o_tx_busy, 0);
    check("rst_rx_valid", o_rx_valid, 0);
    check("rst_rx_data", o_rx_data, 8'h00);
    i_rst = 1'b0;
    loop  = 1'b1;
    repeat (5) @(negedge i_clk);

    // 0xF0 loopback with an ignored request part-way through the frame.
    send_byte(8'hF0);
    fork
      check_frame("f0", 10'b1111100000);
      begin
        repeat (3000) @(negedge i_clk);
        i_tx_data  = 8'h33;
        i_tx_valid = 1'b1;
        @(negedge i_clk);
        i_tx_valid = 1'b0;
      end
    join
    check_rx("f0", 8'hF0, 1);
    lows = 0;
    repeat (1200) begin
      @(negedge i_clk);
      if (o_tx !== 1'b1 || o_tx_busy !== 1'b0) lows++;
    end
    check("ignore_no_frame", lows, 0);
    check("ignore_rx_cnt", rx_cnt, 1);

    // 0x5A, then 0xC3 requested on the first cycle busy is low.
    send_byte(8'h5A);
    check_frame("5a", 10'b1010110100);
    check_rx("5a", 8'h5A, 2);
    send_byte(8'hC3);
    check_frame("c3", 10'b1110000110);
    check_rx("c3", 8'hC3, 3);

    // Driven RX: 0xA5 with a low stop bit, then a short low glitch.
    loop = 1'b0;
    repeat (20) @(negedge i_clk);
    drive_rx(10'b0101001010);
    repeat (100) @(negedge i_clk);
    check("ferr_rx_cnt", rx_cnt, 3);
    check("ferr_rx_data", o_rx_data, 8'hC3);
    rx_drv = 1'b0;
    repeat (300) @(negedge i_clk);
    rx_drv = 1'b1;
    repeat (1200) @(negedge i_clk);
    check("glitch_rx_cnt", rx_cnt, 3);
    check("glitch_rx_data", o_rx_data, 8'hC3);
    drive_rx(10'b1001111000);
    repeat (20) @(negedge i_clk);
    check("recover_rx_cnt", rx_cnt, 4);
    check("recover_rx_data", o_rx_data, 8'h3C);

    // Reset in the middle of data bit 3 of 0x81, then a clean resend.
    loop = 1'b1;
    repeat (20) @(negedge i_clk);
    send_byte(8'h81);
    repeat (4 * CPB + HALF) @(negedge i_clk);
    check("midrst_tx_before", o_tx, 0);
    check("midrst_busy_before", o_tx_busy, 1);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("midrst_tx", o_tx, 1);
    check("midrst_busy", o_tx_busy, 0);
    check("midrst_rx_data", o_rx_data, 8'h00);
    i_rst = 1'b0;
    repeat (2 * CPB) @(negedge i_clk);
    check("midrst_rx_cnt", rx_cnt, 4);
    send_byte(8'h81);
    check_frame("81", 10'b1100000010);
    check_rx("81", 8'h81, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
